// File: rtl/div_issue_ctrl_pkg.sv
// Shared ALU definitions for the divider issue/capture stage.
// Holds the FSM state type, default sizing and the captured response bundle.
package div_issue_ctrl_pkg;

  localparam int DIV_WIDTH      = 16;
  localparam int DIV_SETTLE_CYC = 2;
  localparam int DIV_TAG_W      = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    RESP   = 2'd2
  } div_state_e;

  typedef struct packed {
    logic [DIV_WIDTH-1:0] quo;
    logic [DIV_WIDTH-1:0] rem;
    logic                 dvf;
    logic                 ze;
  } div_rsp_t;

endpackage : div_issue_ctrl_pkg

// File: rtl/div_issue_ctrl_if.sv
// Request, divider and response buses of the divider issue stage.
// The slave modport is the controller's view; master is the surrounding ALU.
interface div_issue_ctrl_if
  import div_issue_ctrl_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH,
  parameter int TAG_W = DIV_TAG_W
) ();

  logic             req_valid;
  logic             req_ready;
  logic [WIDTH-1:0] req_dividend;
  logic [WIDTH-1:0] req_divisor;
  logic [TAG_W-1:0] req_tag;

  logic [WIDTH-1:0] div_q;
  logic [WIDTH-1:0] div_m;
  logic [WIDTH-1:0] div_quo;
  logic [WIDTH-1:0] div_rem;
  logic             div_dvf;
  logic             div_ze;

  logic             rsp_valid;
  logic             rsp_ready;
  logic [WIDTH-1:0] rsp_quo;
  logic [WIDTH-1:0] rsp_rem;
  logic             rsp_dvf;
  logic             rsp_ze;
  logic [TAG_W-1:0] rsp_tag;

  logic             busy;

  modport master (
    output req_valid, req_dividend, req_divisor, req_tag,
    output div_quo, div_rem, div_dvf, div_ze,
    output rsp_ready,
    input  req_ready, div_q, div_m,
    input  rsp_valid, rsp_quo, rsp_rem, rsp_dvf, rsp_ze, rsp_tag,
    input  busy
  );

  modport slave (
    input  req_valid, req_dividend, req_divisor, req_tag,
    input  div_quo, div_rem, div_dvf, div_ze,
    input  rsp_ready,
    output req_ready, div_q, div_m,
    output rsp_valid, rsp_quo, rsp_rem, rsp_dvf, rsp_ze, rsp_tag,
    output busy
  );

endinterface : div_issue_ctrl_if

// File: rtl/div_stats_cnt.sv
// Saturating operation / zero-divide counter pair for the divider issue stage.
// Only instantiated when DIV_STATS_EN is defined.
module div_stats_cnt (
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        inc_ops,
  input  logic        inc_ze,
  output logic [15:0] ops,
  output logic [15:0] ze
);

  logic [15:0] ops_q, ops_d;
  logic [15:0] ze_q, ze_d;

  // A clear always beats an increment landing on the same edge.
  always_comb begin
    ops_d = ops_q;
    ze_d  = ze_q;
    if (clr) begin
      ops_d = '0;
      ze_d  = '0;
    end else begin
      if (inc_ops && (ops_q != 16'hFFFF)) ops_d = ops_q + 16'd1;
      if (inc_ze && (ze_q != 16'hFFFF))   ze_d  = ze_q + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ops_q <= '0;
      ze_q  <= '0;
    end else begin
      ops_q <= ops_d;
      ze_q  <= ze_d;
    end
  end

  assign ops = ops_q;
  assign ze  = ze_q;

endmodule : div_stats_cnt

// File: rtl/div_issue_ctrl.sv
// Issue/capture stage in front of the combinational signed divider.
// Optional statistics counters are enabled by defining DIV_STATS_EN.
module div_issue_ctrl
  import div_issue_ctrl_pkg::*;
#(
  parameter int WIDTH      = DIV_WIDTH,
  parameter int SETTLE_CYC = DIV_SETTLE_CYC,
  parameter int TAG_W      = DIV_TAG_W
) (
  input  logic             clk,
  input  logic             rst,
  div_issue_ctrl_if.slave  bus
`ifdef DIV_STATS_EN
  ,
  input  logic             stat_clr,
  output logic [15:0]      stat_ops,
  output logic [15:0]      stat_ze
`endif
);

  localparam int CNT_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;

  div_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] div_q_q, div_q_d;
  logic [WIDTH-1:0] div_m_q, div_m_d;
  logic [TAG_W-1:0] tag_q, tag_d;
  div_rsp_t         rsp_q, rsp_d;

  // A zero divisor bypasses the settle window; the divider result is ignored.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    div_q_d = div_q_q;
    div_m_d = div_m_q;
    tag_d   = tag_q;
    rsp_d   = rsp_q;
    case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          div_q_d = bus.req_dividend;
          div_m_d = bus.req_divisor;
          tag_d   = bus.req_tag;
          if (bus.req_divisor != '0) begin
            state_d = SETTLE;
            cnt_d   = CNT_W'(SETTLE_CYC - 1);
          end else begin
            state_d   = RESP;
            rsp_d.quo = '0;
            rsp_d.rem = bus.req_dividend;
            rsp_d.dvf = 1'b0;
            rsp_d.ze  = 1'b1;
          end
        end
      end
      SETTLE: begin
        if (cnt_q == '0) begin
          state_d   = RESP;
          rsp_d.quo = bus.div_quo;
          rsp_d.rem = bus.div_rem;
          rsp_d.dvf = bus.div_dvf;
          rsp_d.ze  = bus.div_ze;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      RESP: begin
        if (bus.rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      div_q_q <= '0;
      div_m_q <= '0;
      tag_q   <= '0;
      rsp_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      div_q_q <= div_q_d;
      div_m_q <= div_m_d;
      tag_q   <= tag_d;
      rsp_q   <= rsp_d;
    end
  end

  assign bus.req_ready = (state_q == IDLE);
  assign bus.busy      = (state_q != IDLE);
  assign bus.rsp_valid = (state_q == RESP);
  assign bus.div_q     = div_q_q;
  assign bus.div_m     = div_m_q;
  assign bus.rsp_quo   = rsp_q.quo;
  assign bus.rsp_rem   = rsp_q.rem;
  assign bus.rsp_dvf   = rsp_q.dvf;
  assign bus.rsp_ze    = rsp_q.ze;
  assign bus.rsp_tag   = tag_q;

`ifdef DIV_STATS_EN
  logic rsp_hs;

  assign rsp_hs = (state_q == RESP) && bus.rsp_ready;

  div_stats_cnt u_stats (
    .clk     (clk),
    .rst     (rst),
    .clr     (stat_clr),
    .inc_ops (rsp_hs),
    .inc_ze  (rsp_hs && rsp_q.ze),
    .ops     (stat_ops),
    .ze      (stat_ze)
  );
`endif

endmodule : div_issue_ctrl

// File: tb/tb_div_issue_ctrl.sv
// Directed self-checking bench for div_issue_ctrl with a behavioural divider.
// Statistics checks are compiled in when DIV_STATS_EN is defined.
module tb_div_issue_ctrl;
  import div_issue_ctrl_pkg::*;

  logic clk;
  logic rst;
  int   errors;
  int   checks;

  div_issue_ctrl_if #(.WIDTH(16), .TAG_W(4)) bus ();

`ifdef DIV_STATS_EN
  logic        stat_clr;
  logic [15:0] stat_ops;
  logic [15:0] stat_ze;
`endif

  div_issue_ctrl #(.WIDTH(16), .SETTLE_CYC(2), .TAG_W(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus)
`ifdef DIV_STATS_EN
    ,
    .stat_clr (stat_clr),
    .stat_ops (stat_ops),
    .stat_ze  (stat_ze)
`endif
  );

  always #5 clk = ~clk;

  // Reference divider; a zero divisor yields junk that the stage must ignore.
  always_comb begin
    bus.div_quo = 16'h0000;
    bus.div_rem = 16'h0000;
    bus.div_dvf = 1'b0;
    bus.div_ze  = 1'b0;
    if (bus.div_m == 16'h0000) begin
      bus.div_quo = 16'hDEAD;
      bus.div_rem = 16'hBEEF;
      bus.div_dvf = 1'b1;
      bus.div_ze  = 1'b1;
    end else if (bus.div_q == 16'h8000 && bus.div_m == 16'hFFFF) begin
      bus.div_quo = 16'h8000;
      bus.div_dvf = 1'b1;
    end else begin
      bus.div_quo = 16'($signed(bus.div_q) / $signed(bus.div_m));
      bus.div_rem = 16'($signed(bus.div_q) % $signed(bus.div_m));
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [15:0] dvd, input logic [15:0] dvs, input logic [3:0] tag);
    bus.req_dividend = dvd;
    bus.req_divisor  = dvs;
    bus.req_tag      = tag;
    bus.req_valid    = 1'b1;
    tick();
    bus.req_valid    = 1'b0;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    errors = 0;
    checks = 0;
    clk = 1'b0;
    rst = 1'b1;
    bus.req_valid    = 1'b0;
    bus.req_dividend = 16'h0000;
    bus.req_divisor  = 16'h0000;
    bus.req_tag      = 4'h0;
    bus.rsp_ready    = 1'b1;
`ifdef DIV_STATS_EN
    stat_clr = 1'b0;
`endif

    #2;
    checkOutput("reset_req_ready", bus.req_ready, 1);
    checkOutput("reset_busy", bus.busy, 0);
    checkOutput("reset_rsp_valid", bus.rsp_valid, 0);
    checkOutput("reset_rsp_quo", bus.rsp_quo, 0);
    checkOutput("reset_div_q", bus.div_q, 0);
    #10;
    rst = 1'b0;

    $display("[TB] test 1: 100 / 7");
    applyStimulus(16'd100, 16'd7, 4'h3);
    checkOutput("t1_busy", bus.busy, 1);
    checkOutput("t1_req_ready", bus.req_ready, 0);
    checkOutput("t1_div_q", bus.div_q, 16'h0064);
    checkOutput("t1_div_m", bus.div_m, 16'h0007);
    checkOutput("t1_valid_e1", bus.rsp_valid, 0);
    tick();
    checkOutput("t1_valid_e2", bus.rsp_valid, 0);
    tick();
    checkOutput("t1_valid_e3", bus.rsp_valid, 1);
    checkOutput("t1_quo", bus.rsp_quo, 16'h000E);
    checkOutput("t1_rem", bus.rsp_rem, 16'h0002);
    checkOutput("t1_dvf", bus.rsp_dvf, 0);
    checkOutput("t1_ze", bus.rsp_ze, 0);
    checkOutput("t1_tag", bus.rsp_tag, 4'h3);
    tick();
    checkOutput("t1_idle_valid", bus.rsp_valid, 0);
    checkOutput("t1_idle_ready", bus.req_ready, 1);
    checkOutput("t1_idle_busy", bus.busy, 0);

    $display("[TB] test 2: -7 / 2 with operand churn");
    applyStimulus(16'hFFF9, 16'h0002, 4'h5);
    bus.req_dividend = 16'h7777;
    bus.req_divisor  = 16'h0000;
    checkOutput("t2_div_q_e1", bus.div_q, 16'hFFF9);
    checkOutput("t2_div_m_e1", bus.div_m, 16'h0002);
    tick();
    checkOutput("t2_div_q_e2", bus.div_q, 16'hFFF9);
    checkOutput("t2_div_m_e2", bus.div_m, 16'h0002);
    checkOutput("t2_valid_e2", bus.rsp_valid, 0);
    tick();
    checkOutput("t2_valid_e3", bus.rsp_valid, 1);
    checkOutput("t2_quo", bus.rsp_quo, 16'hFFFD);
    checkOutput("t2_rem", bus.rsp_rem, 16'hFFFF);
    checkOutput("t2_tag", bus.rsp_tag, 4'h5);
    tick();
    checkOutput("t2_idle_ready", bus.req_ready, 1);

    $display("[TB] test 3: zero divisor");
    applyStimulus(16'h1234, 16'h0000, 4'h9);
    checkOutput("t3_valid", bus.rsp_valid, 1);
    checkOutput("t3_ze", bus.rsp_ze, 1);
    checkOutput("t3_quo", bus.rsp_quo, 16'h0000);
    checkOutput("t3_rem", bus.rsp_rem, 16'h1234);
    checkOutput("t3_dvf", bus.rsp_dvf, 0);
    checkOutput("t3_tag", bus.rsp_tag, 4'h9);
    tick();
    checkOutput("t3_idle_valid", bus.rsp_valid, 0);

    $display("[TB] overflow: -32768 / -1");
    applyStimulus(16'h8000, 16'hFFFF, 4'h1);
    tick();
    tick();
    checkOutput("ovf_valid", bus.rsp_valid, 1);
    checkOutput("ovf_quo", bus.rsp_quo, 16'h8000);
    checkOutput("ovf_rem", bus.rsp_rem, 16'h0000);
    checkOutput("ovf_dvf", bus.rsp_dvf, 1);
    checkOutput("ovf_ze", bus.rsp_ze, 0);
    tick();

    $display("[TB] test 4: backpressure");
    bus.rsp_ready = 1'b0;
    applyStimulus(16'h0064, 16'hFFFD, 4'hA);
    tick();
    tick();
    checkOutput("t4_valid", bus.rsp_valid, 1);
    checkOutput("t4_quo", bus.rsp_quo, 16'hFFDF);
    checkOutput("t4_rem", bus.rsp_rem, 16'h0001);
    bus.req_valid    = 1'b1;
    bus.req_dividend = 16'h0050;
    bus.req_divisor  = 16'h0004;
    bus.req_tag      = 4'hF;
    for (int i = 0; i < 5; i++) begin
      tick();
      checkOutput("t4_hold_valid", bus.rsp_valid, 1);
      checkOutput("t4_hold_quo", bus.rsp_quo, 16'hFFDF);
      checkOutput("t4_hold_tag", bus.rsp_tag, 4'hA);
      checkOutput("t4_hold_ready", bus.req_ready, 0);
      checkOutput("t4_hold_div_q", bus.div_q, 16'h0064);
    end
    bus.req_valid = 1'b0;
    bus.rsp_ready = 1'b1;
    tick();
    checkOutput("t4_rel_valid", bus.rsp_valid, 0);
    checkOutput("t4_rel_ready", bus.req_ready, 1);
    checkOutput("t4_rel_div_q", bus.div_q, 16'h0064);

    $display("[TB] test 5: reset during settle");
    applyStimulus(16'h0032, 16'h0005, 4'h6);
    checkOutput("t5_busy_pre", bus.busy, 1);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("t5_rst_busy", bus.busy, 0);
    checkOutput("t5_rst_valid", bus.rsp_valid, 0);
    checkOutput("t5_rst_quo", bus.rsp_quo, 16'h0000);
    checkOutput("t5_rst_rem", bus.rsp_rem, 16'h0000);
    checkOutput("t5_rst_tag", bus.rsp_tag, 4'h0);
    checkOutput("t5_rst_div_q", bus.div_q, 16'h0000);
    checkOutput("t5_rst_ready", bus.req_ready, 1);
    #2;
    rst = 1'b0;
    tick();
    tick();
    checkOutput("t5_no_rsp_valid", bus.rsp_valid, 0);
    checkOutput("t5_no_rsp_busy", bus.busy, 0);
    applyStimulus(16'h0032, 16'h0005, 4'h6);
    tick();
    tick();
    checkOutput("t5_next_valid", bus.rsp_valid, 1);
    checkOutput("t5_next_quo", bus.rsp_quo, 16'h000A);
    checkOutput("t5_next_rem", bus.rsp_rem, 16'h0000);
    checkOutput("t5_next_tag", bus.rsp_tag, 4'h6);
    tick();

`ifdef DIV_STATS_EN
    $display("[TB] test 6: statistics");
    checkOutput("t6_ops_1", stat_ops, 16'd1);
    checkOutput("t6_ze_0", stat_ze, 16'd0);
    applyStimulus(16'h0011, 16'h0000, 4'h2);
    tick();
    applyStimulus(16'h0007, 16'h0002, 4'h3);
    tick();
    tick();
    tick();
    checkOutput("t6_ops_3", stat_ops, 16'd3);
    checkOutput("t6_ze_1", stat_ze, 16'd1);
    stat_clr = 1'b1;
    tick();
    stat_clr = 1'b0;
    checkOutput("t6_clr_ops", stat_ops, 16'd0);
    checkOutput("t6_clr_ze", stat_ze, 16'd0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_div_issue_ctrl
